nonce_result_scheduler: RTL and testbench

Collects golden-nonce results from SLAVES sources (local hashcores after clock-domain sync, plus slave_receive ports) and buffers them in a small FIFO. It arbitrates round-robin among the sources and sequences serial_transmit through its send/busy handshake. It sits in the uart clock domain between the per-slave new_nonce pulses and the host TxD transmitter. It also flushes stale results when new work arrives.

---
 rtl/nonce_result_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_nonce_result_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_result_scheduler.sv
// Collects golden-nonce results from SLAVES sources, arbitrates them round-robin
// into a small result FIFO and sequences the serial transmitter's send/busy handshake.
module nonce_result_scheduler #(
   parameter int SLAVES     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int DEDUP      = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [SLAVES*32-1:0]   slave_nonces,
   input  logic [SLAVES-1:0]      new_nonces,
   input  logic                   work_flush,
   input  logic                   serial_busy,
   output logic                   serial_send,
   output logic [31:0]            golden_nonce,
   output logic [SLAVES-1:0]      pending,
   output logic [7:0]             overflow_count
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int IW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
   localparam int CW = $clog2(SLAVES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } tx_state_t;

   // Capture / arbitration state
   logic [SLAVES-1:0] r_pend;
   logic [31:0]       r_hold [SLAVES];
   logic [IW-1:0]     r_rr;
   logic [7:0]        r_ovf;

   // Result FIFO
   logic [31:0]       r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic [31:0]       r_last;
   logic              r_last_vld;

   // Transmit sequencer
   tx_state_t         r_state;
   tx_state_t         w_state_nxt;
   logic              r_guard;
   logic              r_send;
   logic [31:0]       r_gold;

   logic              w_full;
   logic              w_empty;
   logic              w_pop;
   logic              w_any;
   logic [IW-1:0]     w_any_idx;
   logic              w_gnt;
   logic [31:0]       w_gnt_val;
   logic              w_dup;
   logic              w_push;
   logic [CW-1:0]     w_ovf_inc;

   function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= SLAVES) s = s - SLAVES;
      return s[IW-1:0];
   endfunction

   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [CW-1:0] b);
      logic [8:0] s;
      s = {1'b0, a} + 9'(b);
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);

   // Round-robin search from rr+1; iterating downward lets the nearest candidate win.
   always_comb begin
      w_any     = 1'b0;
      w_any_idx = '0;
      for (int k = SLAVES; k >= 1; k--) begin
         if (r_pend[wrap_idx(r_rr, k)]) begin
            w_any     = 1'b1;
            w_any_idx = wrap_idx(r_rr, k);
         end
      end
   end

   // A pop in the same cycle frees a slot, so a full FIFO can still accept the grant.
   assign w_gnt     = w_any && (!w_full || w_pop);
   assign w_gnt_val = r_hold[w_any_idx];
   assign w_dup     = (DEDUP != 0) && r_last_vld && (w_gnt_val == r_last);
   assign w_push    = w_gnt && !w_dup && !work_flush;

   always_comb begin
      w_ovf_inc = '0;
      for (int i = 0; i < SLAVES; i++) begin
         if (new_nonces[i] && r_pend[i] && !(w_gnt && (w_any_idx == IW'(i)))) begin
            w_ovf_inc = w_ovf_inc + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
         r_rr   <= '0;
         r_ovf  <= '0;
         for (int i = 0; i < SLAVES; i++) r_hold[i] <= '0;
      end else if (work_flush) begin
         r_pend <= '0;
      end else begin
         if (w_gnt) r_rr <= w_any_idx;
         r_ovf <= sat_add(r_ovf, w_ovf_inc);
         for (int i = 0; i < SLAVES; i++) begin
            if (new_nonces[i]) begin
               r_hold[i] <= slave_nonces[i*32 +: 32];
               r_pend[i] <= 1'b1;
            end else if (w_gnt && (w_any_idx == IW'(i))) begin
               r_pend[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_gnt_val;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_last     <= '0;
         r_last_vld <= 1'b0;
      end else if (work_flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_last_vld <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr   <= r_wr_ptr + AW'(1);
            r_last     <= w_gnt_val;
            r_last_vld <= 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

   // A flush also suppresses starting a new send, since the head is being discarded.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty && !serial_busy && !work_flush) begin
               w_pop       = 1'b1;
               w_state_nxt = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            if (serial_busy || r_guard) w_state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (!serial_busy) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_guard <= 1'b0;
         r_send  <= 1'b0;
         r_gold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_guard <= (r_state == S_WAIT_BUSY) && (w_state_nxt == S_WAIT_BUSY);
         r_send  <= w_pop;
         if (w_pop) r_gold <= r_mem[r_rd_ptr];
      end
   end

   assign serial_send    = r_send;
   assign golden_nonce   = r_gold;
   assign pending        = r_pend;
   assign overflow_count = r_ovf;

endmodule

// File: tb/tb_nonce_result_scheduler.sv
// Bench for nonce_result_scheduler: directed scenarios plus random traffic, all
// compared each cycle against a queue-based behavioural model of the scheduler.
module tb_nonce_result_scheduler;

   localparam int SLAVES     = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int DEDUP      = 1;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [SLAVES*32-1:0] slave_nonces;
   logic [SLAVES-1:0]    new_nonces;
   logic                 work_flush;
   logic                 serial_busy;
   logic                 serial_send;
   logic [31:0]          golden_nonce;
   logic [SLAVES-1:0]    pending;
   logic [7:0]           overflow_count;

   always #5 clk = ~clk;

   nonce_result_scheduler #(
      .SLAVES    (SLAVES),
      .FIFO_DEPTH(FIFO_DEPTH),
      .DEDUP     (DEDUP)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .slave_nonces  (slave_nonces),
      .new_nonces    (new_nonces),
      .work_flush    (work_flush),
      .serial_busy   (serial_busy),
      .serial_send   (serial_send),
      .golden_nonce  (golden_nonce),
      .pending       (pending),
      .overflow_count(overflow_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Behavioural reference: results flow hold -> queue -> transmitter
   bit          m_pend [SLAVES];
   logic [31:0] m_hold [SLAVES];
   logic [31:0] m_q [$];
   logic [31:0] m_last;
   bit          m_last_vld;
   int          m_rr;
   int          m_ovf;
   logic [31:0] m_gold;
   bit          m_send;
   int          m_phase;   // 0 ready, 1 awaiting busy, 2 awaiting completion
   int          m_wait;

   task automatic model_reset();
      foreach (m_pend[i]) begin
         m_pend[i] = 1'b0;
         m_hold[i] = '0;
      end
      m_q.delete();
      m_last = '0;
      m_last_vld = 1'b0;
      m_rr = 0;
      m_ovf = 0;
      m_gold = '0;
      m_send = 1'b0;
      m_phase = 0;
      m_wait = 0;
   endtask

   task automatic model_step();
      bit          start;
      bit          gv;
      int          gi;
      bit          old_pend [SLAVES];
      logic [31:0] v;
      start = 1'b0;
      case (m_phase)
         0: start = (m_q.size() != 0) && !serial_busy && !work_flush;
         1: begin
            if (serial_busy || m_wait >= 1) m_phase = 2;
            else m_wait++;
         end
         default: if (!serial_busy) m_phase = 0;
      endcase
      gv = 1'b0;
      gi = 0;
      if (m_q.size() < FIFO_DEPTH || start) begin
         for (int k = 1; k <= SLAVES; k++) begin
            if (!gv && m_pend[(m_rr + k) % SLAVES]) begin
               gv = 1'b1;
               gi = (m_rr + k) % SLAVES;
            end
         end
      end
      old_pend = m_pend;
      m_send = start;
      if (start) begin
         m_gold = m_q.pop_front();
         m_phase = 1;
         m_wait = 0;
      end
      if (work_flush) begin
         m_q.delete();
         m_last_vld = 1'b0;
         foreach (m_pend[i]) m_pend[i] = 1'b0;
      end else begin
         if (gv) begin
            v = m_hold[gi];
            m_rr = gi;
            m_pend[gi] = 1'b0;
            if (!(DEDUP != 0 && m_last_vld && v == m_last)) begin
               m_q.push_back(v);
               m_last = v;
               m_last_vld = 1'b1;
            end
         end
         for (int i = 0; i < SLAVES; i++) begin
            if (new_nonces[i]) begin
               if (old_pend[i] && !(gv && gi == i) && m_ovf < 255) m_ovf++;
               m_hold[i] = slave_nonces[i*32 +: 32];
               m_pend[i] = 1'b1;
            end
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // Transmitter stand-in, send log and per-cycle comparison
   bit          auto_busy = 1'b1;
   bit          man_busy  = 1'b0;
   bit          rand_len  = 1'b0;
   int          busy_cnt  = 0;
   logic [31:0] sent_q [$];

   initial begin
      logic [SLAVES-1:0] mp;
      serial_busy = 1'b0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < SLAVES; i++) mp[i] = m_pend[i];
         chk("send", 32'(serial_send), 32'(m_send));
         chk("golden", golden_nonce, m_gold);
         chk("pending", 32'(pending), 32'(mp));
         chk("ovf", 32'(overflow_count), 32'(m_ovf));
         if (serial_send) sent_q.push_back(golden_nonce);
         if (!auto_busy) begin
            serial_busy = man_busy;
         end else begin
            if (serial_send) busy_cnt = rand_len ? $urandom_range(0, 12) : 10;
            serial_busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
         end
      end
   end

   function automatic logic [31:0] sent_at(input int i);
      return (sent_q.size() > i) ? sent_q[i] : 32'hxxxx_xxxx;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic [SLAVES-1:0] m, input logic [31:0] a, input logic [31:0] b);
      new_nonces   = m;
      slave_nonces = {b, a};
      @(negedge clk);
      new_nonces = '0;
   endtask

   int base;

   initial begin
      new_nonces   = '0;
      slave_nonces = '0;
      work_flush   = 1'b0;
      idle(3);
      #1;
      chk("rst_send", 32'(serial_send), 32'd0);
      chk("rst_golden", golden_nonce, 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_ovf", 32'(overflow_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Single result and its latency
      base = sent_q.size();
      pulse(2'b01, 32'h1234_5678, 32'h0);
      idle(2);
      #1;
      chk("lat_send", 32'(serial_send), 32'd1);
      chk("lat_golden", golden_nonce, 32'h1234_5678);
      idle(30);
      chk("single_cnt", 32'(sent_q.size() - base), 32'd1);
      chk("single_val", sent_at(base), 32'h1234_5678);

      // Simultaneous pulses: rr=0 so slave1 is served first
      base = sent_q.size();
      pulse(2'b11, 32'hA, 32'hB);
      idle(40);
      chk("pair_cnt", 32'(sent_q.size() - base), 32'd2);
      chk("pair_first", sent_at(base), 32'hB);
      chk("pair_second", sent_at(base + 1), 32'hA);
      base = sent_q.size();
      pulse(2'b11, 32'hC, 32'hD);
      idle(40);
      chk("pair2_cnt", 32'(sent_q.size() - base), 32'd2);

      // Overflow with transmitter held busy
      auto_busy = 1'b0;
      man_busy  = 1'b1;
      idle(2);
      base = sent_q.size();
      for (int k = 0; k < 7; k++) pulse(2'b01, 32'h100 + 32'(k), 32'h0);
      idle(3);
      chk("ovf_count", 32'(overflow_count), 32'd2);
      chk("ovf_pending", 32'(pending), 32'd1);
      busy_cnt  = 0;
      auto_busy = 1'b1;
      idle(100);
      chk("ovf_sends", 32'(sent_q.size() - base), 32'd5);
      for (int k = 0; k < 4; k++) chk("ovf_order", sent_at(base + k), 32'h100 + 32'(k));
      chk("ovf_last", sent_at(base + 4), 32'h106);

      // Dedup, then the same value after a flush
      base = sent_q.size();
      pulse(2'b10, 32'h0, 32'hDEAD_BEEF);
      idle(5);
      pulse(2'b10, 32'h0, 32'hDEAD_BEEF);
      idle(30);
      chk("dedup_cnt", 32'(sent_q.size() - base), 32'd1);
      work_flush = 1'b1;
      @(negedge clk);
      work_flush = 1'b0;
      pulse(2'b10, 32'h0, 32'hDEAD_BEEF);
      idle(30);
      chk("dedup_flush_cnt", 32'(sent_q.size() - base), 32'd2);
      chk("dedup_flush_val", sent_at(base + 1), 32'hDEAD_BEEF);

      // Flush while a word is in flight, with a coincident pulse
      base = sent_q.size();
      for (int k = 0; k < 3; k++) pulse(2'b01, 32'h51 + 32'(k), 32'h0);
      idle(2);
      work_flush   = 1'b1;
      new_nonces   = 2'b10;
      slave_nonces = {32'h99, 32'h0};
      @(negedge clk);
      work_flush = 1'b0;
      new_nonces = '0;
      idle(50);
      chk("flush_cnt", 32'(sent_q.size() - base), 32'd1);
      chk("flush_val", sent_at(base), 32'h51);
      chk("flush_pending", 32'(pending), 32'd0);
      chk("flush_ovf", 32'(overflow_count), 32'd2);

      // Asynchronous reset during WAIT_DONE
      for (int k = 0; k < 3; k++) pulse(2'b01, 32'h61 + 32'(k), 32'h0);
      idle(3);
      #2;
      rst_n    = 1'b0;
      busy_cnt = 0;
      #1;
      chk("arst_send", 32'(serial_send), 32'd0);
      chk("arst_golden", golden_nonce, 32'd0);
      chk("arst_pending", 32'(pending), 32'd0);
      chk("arst_ovf", 32'(overflow_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      base = sent_q.size();
      idle(20);
      chk("arst_nosend", 32'(sent_q.size() - base), 32'd0);
      pulse(2'b01, 32'h77, 32'h0);
      idle(30);
      chk("arst_new_cnt", 32'(sent_q.size() - base), 32'd1);
      chk("arst_new_val", sent_at(base), 32'h77);

      // Random traffic with variable busy length (including none)
      rand_len = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < SLAVES; i++) begin
            new_nonces[i] = ($urandom_range(0, 5) == 0);
            slave_nonces[i*32 +: 32] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3))
                                                                   : 32'($urandom());
         end
         work_flush = ($urandom_range(0, 99) == 0);
         @(negedge clk);
      end
      new_nonces = '0;
      work_flush = 1'b0;
      idle(200);
      chk("drain_pending", 32'(pending), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
